// File: rtl/dlfloat_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dlfloat_pkg
// Description : Shared definitions for the DLFloat add/sub pipeline.
//               - bias(): exponent bias for a given exponent width
//               - NAN_INF_WORD / ZERO_WORD: wide constants, sliced to the word
//                 width by users (all-ones = NaN/Inf, all-zeros = +0)
//               - FLAG_*: bit positions inside the 3-bit flags vector
// Revision    : 1.0 - initial release
// ============================================================================
package dlfloat_pkg;

    localparam int FLAG_OVF = 2;
    localparam int FLAG_UNF = 1;
    localparam int FLAG_INX = 0;

    localparam logic [63:0] NAN_INF_WORD = '1;
    localparam logic [63:0] ZERO_WORD    = '0;

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dlfloat_lzc.sv
`default_nettype none
// ============================================================================
// Module      : dlfloat_lzc
// Description : Parametrised leading-zero counter.
//   i_vec    in   WIDTH  vector to scan (MSB first)
//   o_count  out  CNT_W  number of zeros above the highest set bit
//                        (WIDTH when i_vec is all zeros)
// Revision    : 1.0 - initial release
// ============================================================================
module dlfloat_lzc #(
    parameter int WIDTH = 14,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic [CNT_W-1:0] o_count
);

    // Scan upward; the last hit is the highest set bit.
    always_comb begin
        o_count = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (i_vec[i]) begin
                o_count = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dlfloat_add_sub_pipe.sv
`default_nettype none
// ============================================================================
// Module      : dlfloat_add_sub_pipe
// Description : 3-stage DLFloat adder/subtractor with valid/ready handshake.
//   clk, rst           clock, synchronous active-high reset
//   in_valid/in_ready  operand handshake; a, b, op sampled on transfer
//   a, b               operands {sign, exp, man}; op 0 = a+b, 1 = a-b
//   c_out, flags       result and {overflow, underflow, inexact}
//   out_valid/out_ready result handshake
// Stages: S1 unpack/swap/align, S2 mantissa add/sub, S3 normalise/round/pack.
// Revision    : 1.0 - initial release
// ============================================================================
module dlfloat_add_sub_pipe
    import dlfloat_pkg::*;
#(
    parameter int EXP_W = 6,
    parameter int MAN_W = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic                 op,
    output logic [EXP_W+MAN_W:0] c_out,
    output logic [2:0]           flags,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int c_w   = 1 + EXP_W + MAN_W;
    localparam int c_mw  = MAN_W + 4;          // hidden + stored + guard/round/sticky
    localparam int c_sw  = MAN_W + 5;          // aligned width plus carry
    localparam int c_ew  = EXP_W + 2;          // exponent workspace, MSB = sign
    localparam int c_lzw = $clog2(c_sw + 1);

    localparam logic [c_w-1:0]   c_nan      = NAN_INF_WORD[c_w-1:0];
    localparam logic [c_w-1:0]   c_zero     = ZERO_WORD[c_w-1:0];
    localparam logic [EXP_W-1:0] c_collapse = EXP_W'(MAN_W + 3);
    localparam logic [c_ew-1:0]  c_exp_max  = c_ew'((1 << EXP_W) - 1);

    typedef struct packed {
        logic             valid;
        logic             nan;
        logic             sub;
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [c_mw-1:0]  m_big;
        logic [c_mw-1:0]  m_sml;
    } s1_t;

    typedef struct packed {
        logic             valid;
        logic             nan;
        logic             sub;
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [c_sw-1:0]  sum;
    } s2_t;

    s1_t            s1_d, s1_q;
    s2_t            s2_d, s2_q;
    logic [c_w-1:0] c_out_d, c_out_q;
    logic [2:0]     flags_d, flags_q;
    logic           out_valid_d, out_valid_q;
    logic           en;

    // Whole pipeline moves in lock-step; a held result freezes every stage.
    assign en        = !out_valid_q || out_ready;
    assign in_ready  = en;
    assign c_out     = c_out_q;
    assign flags     = flags_q;
    assign out_valid = out_valid_q;

    // ---------------------------------------------------------------- S1
    logic                sa, sb_eff, za, zb, swap;
    logic [EXP_W-1:0]    ea, eb, e_big, e_sml, e_diff;
    logic [MAN_W-1:0]    ma, mb;
    logic [c_mw-1:0]     m_big, m_sml;
    logic [2*c_mw-1:0]   m_shift;

    always_comb begin
        sa     = a[c_w-1];
        sb_eff = b[c_w-1] ^ op;
        ea     = a[c_w-2:MAN_W];
        eb     = b[c_w-2:MAN_W];
        za     = (ea == '0);
        zb     = (eb == '0);
        // Zero operands contribute no mantissa bits at all (flush-to-zero).
        ma     = za ? '0 : a[MAN_W-1:0];
        mb     = zb ? '0 : b[MAN_W-1:0];
        swap   = {eb, mb} > {ea, ma};
        e_big  = swap ? eb : ea;
        e_sml  = swap ? ea : eb;
        m_big  = swap ? {!zb, mb, 3'b000} : {!za, ma, 3'b000};
        m_sml  = swap ? {!za, ma, 3'b000} : {!zb, mb, 3'b000};
        e_diff = e_big - e_sml;
        // Lower half of the shifted vector holds everything pushed past sticky.
        m_shift = {m_sml, {c_mw{1'b0}}} >> e_diff;

        s1_d = s1_q;
        if (en) begin
            s1_d.valid = in_valid;
            s1_d.nan   = (a == c_nan) || (b == c_nan);
            s1_d.sub   = sa ^ sb_eff;
            s1_d.sign  = swap ? sb_eff : sa;
            s1_d.exp   = e_big;
            s1_d.m_big = m_big;
            if (e_diff >= c_collapse) begin
                s1_d.m_sml = {{(c_mw-1){1'b0}}, |m_sml};
            end else begin
                s1_d.m_sml = m_shift[2*c_mw-1:c_mw]
                           | {{(c_mw-1){1'b0}}, |m_shift[c_mw-1:0]};
            end
        end
    end

    // ---------------------------------------------------------------- S2
    // Operands are ordered by magnitude, so the difference is never negative.
    always_comb begin
        s2_d = s2_q;
        if (en) begin
            s2_d.valid = s1_q.valid;
            s2_d.nan   = s1_q.nan;
            s2_d.sub   = s1_q.sub;
            s2_d.sign  = s1_q.sign;
            s2_d.exp   = s1_q.exp;
            s2_d.sum   = s1_q.sub ? ({1'b0, s1_q.m_big} - {1'b0, s1_q.m_sml})
                                  : ({1'b0, s1_q.m_big} + {1'b0, s1_q.m_sml});
        end
    end

    // ---------------------------------------------------------------- S3
    logic [c_lzw-1:0] lz;
    logic [c_sw-1:0]  norm;
    logic [c_ew-1:0]  e_norm, e_rnd;
    logic [MAN_W+1:0] m_rnd;
    logic [MAN_W-1:0] man_out;
    logic             guard, sticky, round_up, carry, ufl, ovf;

    dlfloat_lzc #(
        .WIDTH (c_sw)
    ) u_lzc (
        .i_vec   (s2_q.sum),
        .o_count (lz)
    );

    always_comb begin
        // After the shift the leading one sits at the carry position, so the
        // exponent gains one for the carry slot and loses one per shift.
        norm     = s2_q.sum << lz;
        e_norm   = c_ew'(s2_q.exp) + c_ew'(1) - c_ew'(lz);
        guard    = norm[3];
        sticky   = |norm[2:0];
        round_up = guard && (sticky || norm[4]);
        m_rnd    = {1'b0, norm[c_sw-1:4]} + {{(MAN_W+1){1'b0}}, round_up};
        carry    = m_rnd[MAN_W+1];
        man_out  = carry ? m_rnd[MAN_W:1] : m_rnd[MAN_W-1:0];
        e_rnd    = e_norm + {{(c_ew-1){1'b0}}, carry};
        ufl      = e_norm[c_ew-1] || (e_norm == '0);
        ovf      = (e_rnd >= c_exp_max);   // only consulted when !ufl

        c_out_d     = c_out_q;
        flags_d     = flags_q;
        out_valid_d = out_valid_q;
        if (en) begin
            out_valid_d = s2_q.valid;
            flags_d     = '0;
            if (s2_q.nan) begin
                c_out_d = c_nan;
            end else if (s2_q.sum == '0) begin
                // Cancellation is +0; adding two zeros keeps their sign.
                c_out_d = {!s2_q.sub && s2_q.sign, c_zero[c_w-2:0]};
            end else if (ufl) begin
                c_out_d           = {s2_q.sign, c_zero[c_w-2:0]};
                flags_d[FLAG_UNF] = 1'b1;
                flags_d[FLAG_INX] = 1'b1;
            end else if (ovf) begin
                // Saturate; inexact still reports only bits lost to rounding.
                c_out_d           = c_nan;
                flags_d[FLAG_OVF] = 1'b1;
                flags_d[FLAG_INX] = guard || sticky;
            end else begin
                c_out_d           = {s2_q.sign, e_rnd[EXP_W-1:0], man_out};
                flags_d[FLAG_INX] = guard || sticky;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q        <= '0;
            s2_q        <= '0;
            c_out_q     <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            c_out_q     <= c_out_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dlfloat_add_sub_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_dlfloat_add_sub_pipe
// Description : Directed, table-driven bench for dlfloat_add_sub_pipe with
//               hand sequences for latency, back-pressure and reset flush.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dlfloat_add_sub_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        op;
    logic [15:0] c_out;
    logic [2:0]  flags;
    logic        out_valid;
    logic        out_ready;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dlfloat_add_sub_pipe #(
        .EXP_W (6),
        .MAN_W (9)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .c_out     (c_out),
        .flags     (flags),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        op;
        logic [15:0] c;
        logic [2:0]  f;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string name, input logic [15:0] va,
                                input logic [15:0] vb, input logic vop,
                                input logic [15:0] vc, input logic [2:0] vf);
        vec_t v;
        v.a = va; v.b = vb; v.op = vop; v.c = vc; v.f = vf; v.name = name;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One operation in isolation: result must appear exactly 3 edges later.
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        a = v.a; b = v.b; op = v.op; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk({v.name, "_in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk({v.name, "_lat1"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        chk({v.name, "_lat2"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        chk({v.name, "_valid"}, 32'(out_valid), 32'd1);
        chk({v.name, "_c_out"}, 32'(c_out), 32'(v.c));
        chk({v.name, "_flags"}, 32'(flags), 32'(v.f));
    endtask

    initial begin
        vecs.push_back(mk("one_plus_one",    16'h3E00, 16'h3E00, 1'b0, 16'h4000, 3'b000));
        vecs.push_back(mk("one_minus_one",   16'h3E00, 16'h3E00, 1'b1, 16'h0000, 3'b000));
        vecs.push_back(mk("one_plus_two",    16'h3E00, 16'h4000, 1'b0, 16'h4100, 3'b000));
        vecs.push_back(mk("overflow",        16'h7DFF, 16'h7DFF, 1'b0, 16'hFFFF, 3'b100));
        vecs.push_back(mk("nan_a",           16'hFFFF, 16'h3E00, 1'b0, 16'hFFFF, 3'b000));
        vecs.push_back(mk("zero_a",          16'h0000, 16'hC200, 1'b0, 16'hC200, 3'b000));
        vecs.push_back(mk("neg_result",      16'h3E00, 16'h4000, 1'b1, 16'hBE00, 3'b000));
        vecs.push_back(mk("sticky_collapse", 16'h3E00, 16'h1600, 1'b0, 16'h3E00, 3'b001));
        vecs.push_back(mk("tie_even_down",   16'h3E00, 16'h2A00, 1'b0, 16'h3E00, 3'b001));
        vecs.push_back(mk("tie_even_up",     16'h3E01, 16'h2A00, 1'b0, 16'h3E02, 3'b001));
        vecs.push_back(mk("round_carry",     16'h3FFF, 16'h2A00, 1'b0, 16'h4000, 3'b001));
        vecs.push_back(mk("underflow",       16'h0201, 16'h0200, 1'b1, 16'h0000, 3'b011));
        vecs.push_back(mk("nan_b",           16'h3E00, 16'hFFFF, 1'b1, 16'hFFFF, 3'b000));
        vecs.push_back(mk("neg_same",        16'hBE00, 16'hBE00, 1'b0, 16'hC000, 3'b000));
        vecs.push_back(mk("zero_b",          16'h4100, 16'h0000, 1'b1, 16'h4100, 3'b000));
        vecs.push_back(mk("three_minus_one", 16'h4100, 16'h3E00, 1'b1, 16'h4000, 3'b000));

        // Reset state
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_c_out",     32'(c_out),     32'd0);
        chk("reset_flags",     32'(flags),     32'd0);
        rst = 1'b0;
        #1;
        chk("reset_in_ready",  32'(in_ready),  32'd1);

        // Table of isolated operations
        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i]);
        end

        // Back-to-back stream of 8 with out_ready low in cycles 4..6
        begin : stream
            int   n_in;
            int   n_out;
            logic stall;
            n_in = 0; n_out = 0;
            @(negedge clk);
            in_valid = 1'b0; out_ready = 1'b1;
            repeat (4) @(negedge clk);
            for (int cyc = 0; cyc < 40 && n_out < 8; cyc++) begin
                stall     = (cyc >= 4 && cyc <= 6);
                in_valid  = (n_in < 8);
                if (n_in < 8) begin
                    a = vecs[n_in].a; b = vecs[n_in].b; op = vecs[n_in].op;
                end
                out_ready = !stall;
                #1;
                if (cyc < 12) begin
                    chk($sformatf("stream_in_ready_c%0d", cyc), 32'(in_ready), 32'(!stall));
                end
                if (out_valid) begin
                    chk($sformatf("stream_c_out_r%0d_c%0d", n_out, cyc), 32'(c_out), 32'(vecs[n_out].c));
                    chk($sformatf("stream_flags_r%0d_c%0d", n_out, cyc), 32'(flags), 32'(vecs[n_out].f));
                    if (out_ready) n_out++;
                end
                if (in_valid && in_ready) n_in++;
                @(negedge clk);
            end
            in_valid = 1'b0; out_ready = 1'b1;
            chk("stream_all_delivered", 32'(n_out), 32'd8);
            for (int k = 0; k < 5; k++) begin
                chk($sformatf("stream_no_extra_%0d", k), 32'(out_valid), 32'd0);
                @(negedge clk);
            end
        end

        // Reset with two operations in flight
        a = 16'h3E00; b = 16'h3E00; op = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        a = 16'h3E00; b = 16'h4000;
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_c_out",     32'(c_out),     32'd0);
        chk("flush_flags",     32'(flags),     32'd0);
        chk("flush_in_ready",  32'(in_ready),  32'd1);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("flush_no_stale_%0d", k), 32'(out_valid), 32'd0);
        end
        run_vec(mk("after_flush", 16'h4100, 16'h3E00, 1'b0, 16'h4200, 3'b000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
